// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-wide memory port arbiter: widths, states, grant
// owner and the IO-space marker.
package mem_arbiter_pkg;

   localparam int ADDR_BITS = 32;
   localparam int INST_BITS = 32;
   localparam int BYTE_BITS = 8;

   typedef logic [ADDR_BITS-1:0] addr_t;
   typedef logic [INST_BITS-1:0] inst_t;
   typedef logic [BYTE_BITS-1:0] byte_t;

   localparam logic [1:0] WIDTH_B = 2'd0;
   localparam logic [1:0] WIDTH_H = 2'd1;
   localparam logic [1:0] WIDTH_W = 2'd2;

   // addr[17:16] value that selects the IO window (0x30000 and up)
   localparam logic [1:0] IO_HI_DEF = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_STORE,
      ST_DONE
   } arb_state_t;

   typedef enum logic {
      GNT_IF  = 1'b0,
      GNT_LSB = 1'b1
   } grant_t;

   function automatic logic [2:0] width_bytes(input logic [1:0] w);
      case (w)
         WIDTH_B: return 3'd1;
         WIDTH_H: return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Owns the single byte-wide RAM/IO port and serialises instruction fetches and
// LSB loads/stores into byte-per-cycle accesses with one-cycle done pulses.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int         ADDR_W = 32,
   parameter logic [1:0] IO_HI  = IO_HI_DEF
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              io_buffer_full,
   input  logic              flush,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [31:0]       if_inst,
   input  logic              lsb_req,
   input  logic              lsb_we,
   input  logic [ADDR_W-1:0] lsb_addr,
   input  logic [1:0]        lsb_width,
   input  logic [31:0]       lsb_wdata,
   output logic              lsb_done,
   output logic [31:0]       lsb_rdata
);

   arb_state_t        state, state_nxt;
   grant_t            last_grant;
   logic [ADDR_W-1:0] base;
   logic [2:0]        nbytes, cnt;
   logic [31:0]       wdata, rbuf, merged;
   logic [1:0]        cap_idx;
   logic              grant_if, grant_lsb, take_if, stall, last_read;
   logic [ADDR_W-1:0] live_a, bus_a;
   logic [7:0]        live_dout, bus_dout;
   logic              live_wr;

   assign grant_lsb = lsb_req & (~if_req | (last_grant == GNT_IF));
   assign grant_if  = if_req & (~lsb_req | (last_grant == GNT_LSB));
   assign take_if   = grant_if & ~flush;
   assign stall     = (state == ST_STORE) & io_buffer_full & (base[17:16] == IO_HI);
   assign last_read = (cnt == nbytes);
   assign cap_idx   = cnt[1:0] - 2'd1;

   // While frozen the bus repeats the previous cycle's access, so the byte that
   // arrives on resume still belongs to the slot the counter expects.
   assign mem_a    = rdy_in ? live_a : bus_a;
   assign mem_dout = rdy_in ? live_dout : bus_dout;
   assign mem_wr   = rdy_in & live_wr;

   always_ff @(posedge clk_in) begin
      if (!rst_in)
         state <= ST_IDLE;
      else if (rdy_in)
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (grant_lsb)
               state_nxt = lsb_we ? ST_STORE : ST_LOAD;
            else if (take_if)
               state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            if (flush)
               state_nxt = ST_IDLE;
            else if (last_read)
               state_nxt = ST_DONE;
         end
         ST_LOAD:  if (last_read) state_nxt = ST_DONE;
         ST_STORE: if (!stall && (cnt == nbytes - 3'd1)) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      live_a    = '0;
      live_dout = '0;
      live_wr   = 1'b0;
      case (state)
         ST_FETCH, ST_LOAD: begin
            if (!last_read)
               live_a = base + ADDR_W'(cnt);
         end
         ST_STORE: begin
            live_a    = base + ADDR_W'(cnt);
            live_dout = wdata[{cnt[1:0], 3'b000} +: 8];
            live_wr   = ~stall;
         end
         default: ;
      endcase
   end

   always_comb begin
      merged = rbuf;
      merged[{cap_idx, 3'b000} +: 8] = mem_din;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         base       <= '0;
         nbytes     <= '0;
         cnt        <= '0;
         wdata      <= '0;
         rbuf       <= '0;
         bus_a      <= '0;
         bus_dout   <= '0;
         last_grant <= GNT_IF;
         if_done    <= 1'b0;
         if_inst    <= '0;
         lsb_done   <= 1'b0;
         lsb_rdata  <= '0;
      end else if (rdy_in) begin
         bus_a    <= live_a;
         bus_dout <= live_dout;
         if_done  <= 1'b0;
         lsb_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_lsb) begin
                  base       <= lsb_addr;
                  nbytes     <= width_bytes(lsb_width);
                  wdata      <= lsb_wdata;
                  last_grant <= GNT_LSB;
                  cnt        <= '0;
                  rbuf       <= '0;
               end else if (take_if) begin
                  base       <= if_addr;
                  nbytes     <= 3'd4;
                  last_grant <= GNT_IF;
                  cnt        <= '0;
                  rbuf       <= '0;
               end
            end
            ST_FETCH, ST_LOAD: begin
               if (cnt != 3'd0)
                  rbuf <= merged;
               if (!last_read)
                  cnt <= cnt + 3'd1;
               else if (state == ST_LOAD) begin
                  lsb_rdata <= merged;
                  lsb_done  <= 1'b1;
               end else if (!flush) begin
                  if_inst <= merged;
                  if_done <= 1'b1;
               end
            end
            ST_STORE: begin
               if (!stall) begin
                  cnt <= cnt + 3'd1;
                  if (cnt == nbytes - 3'd1)
                     lsb_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle-exact bus, done and data checks against
// hand-computed values, with a small byte RAM behind the port.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in;
   logic [7:0]  mem_din = 8'h00;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full, flush;
   logic        if_req, if_done;
   logic [31:0] if_addr, if_inst;
   logic        lsb_req, lsb_we, lsb_done;
   logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
   logic [1:0]  lsb_width;

   int checks = 0;
   int failures = 0;

   logic [7:0] ram [logic [31:0]];

   mem_arbiter dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full), .flush(flush),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
      .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_addr(lsb_addr), .lsb_width(lsb_width),
      .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata)
   );

   always #5 clk_in = ~clk_in;

   // RAM: read data appears the cycle after its address
   always @(posedge clk_in) begin
      mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
      if (mem_wr) ram[mem_a] = mem_dout;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   initial begin
      logic [31:0] wd;
      logic [31:0] stored;
      rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
      if_req = 1'b1; if_addr = 32'h1000;
      lsb_req = 1'b1; lsb_we = 1'b0; lsb_addr = 32'h2000; lsb_width = WIDTH_B; lsb_wdata = '0;
      ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
      ram[32'h2000] = 8'hFF;
      ram[32'h0FFFFFFF] = 8'h34; ram[32'h10000000] = 8'hAB;

      // reset held two cycles with both requesters asserting
      repeat (2) step();
      check("rst_mem_a", mem_a, 32'h0);
      check("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
      check("rst_mem_dout", {24'b0, mem_dout}, 32'h0);
      check("rst_if_done", {31'b0, if_done}, 32'h0);
      check("rst_if_inst", if_inst, 32'h0);
      check("rst_lsb_done", {31'b0, lsb_done}, 32'h0);
      check("rst_lsb_rdata", lsb_rdata, 32'h0);
      rst_in = 1'b1;

      // first tie after reset goes to the LSB: byte load at 0x2000
      step(); check("tie_lsb_addr", mem_a, 32'h2000); check("tie_lsb_wr", {31'b0, mem_wr}, 32'h0);
      step(); check("ldb_done_early", {31'b0, lsb_done}, 32'h0);
      step(); check("ldb_done", {31'b0, lsb_done}, 32'h1); check("ldb_rdata", lsb_rdata, 32'h000000FF);
      check("ldb_no_if_done", {31'b0, if_done}, 32'h0);
      lsb_req = 1'b0;
      step(); check("ldb_done_pulse", {31'b0, lsb_done}, 32'h0);

      // IF granted next: word fetch at 0x1000
      for (int i = 0; i < 4; i++) begin
         step(); check("fetch_addr", mem_a, 32'h1000 + i);
      end
      step(); check("fetch_done_early", {31'b0, if_done}, 32'h0);
      step(); check("fetch_done", {31'b0, if_done}, 32'h1); check("fetch_inst", if_inst, 32'h00000513);
      if_req = 1'b0;
      step(); check("fetch_done_pulse", {31'b0, if_done}, 32'h0);

      // word store into IO space while the IO buffer is full
      lsb_req = 1'b1; lsb_we = 1'b1; lsb_addr = 32'h30000; lsb_width = WIDTH_W;
      lsb_wdata = 32'hDEADBEEF; io_buffer_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(); check("io_stall_wr", {31'b0, mem_wr}, 32'h0);
      end
      step(); io_buffer_full = 1'b0; #1;
      wd = 32'hDEADBEEF;
      for (int i = 0; i < 4; i++) begin
         check("st_wr", {31'b0, mem_wr}, 32'h1);
         check("st_addr", mem_a, 32'h30000 + i);
         check("st_dout", {24'b0, mem_dout}, {24'b0, wd[8*i +: 8]});
         check("st_done_early", {31'b0, lsb_done}, 32'h0);
         if (i < 3) step();
      end
      step(); check("st_done", {31'b0, lsb_done}, 32'h1); check("st_done_wr", {31'b0, mem_wr}, 32'h0);
      stored = {ram[32'h30003], ram[32'h30002], ram[32'h30001], ram[32'h30000]};
      check("st_ram_word", stored, 32'hDEADBEEF);
      lsb_req = 1'b0; lsb_we = 1'b0;

      // tie with last_grant=LSB goes to IF; the fetch is flushed in its cycle 3
      step();
      if_req = 1'b1; if_addr = 32'h1000;
      lsb_req = 1'b1; lsb_addr = 32'h0FFFFFFF; lsb_width = WIDTH_H;
      step(); check("tie_if_addr", mem_a, 32'h1000);
      step(); check("tie_if_addr1", mem_a, 32'h1001);
      step(); flush = 1'b1; if_req = 1'b0;
      step(); flush = 1'b0;
      check("flush_idle_a", mem_a, 32'h0); check("flush_no_done", {31'b0, if_done}, 32'h0);
      step(); check("ldh_addr0", mem_a, 32'h0FFFFFFF);

      // freeze two cycles mid half-load
      step(); rdy_in = 1'b0; #1;
      check("frz_addr", mem_a, 32'h0FFFFFFF); check("frz_wr", {31'b0, mem_wr}, 32'h0);
      check("frz_no_if_done", {31'b0, if_done}, 32'h0);
      step(); check("frz_addr2", mem_a, 32'h0FFFFFFF); check("frz_done", {31'b0, lsb_done}, 32'h0);
      step(); rdy_in = 1'b1; #1;
      check("ldh_addr1", mem_a, 32'h10000000);
      step(); check("ldh_done_early", {31'b0, lsb_done}, 32'h0);
      step(); check("ldh_done", {31'b0, lsb_done}, 32'h1); check("ldh_rdata", lsb_rdata, 32'h0000AB34);
      check("ldh_no_if_done", {31'b0, if_done}, 32'h0);
      lsb_req = 1'b0;
      step(); check("ldh_done_pulse", {31'b0, lsb_done}, 32'h0);
      check("ldh_rdata_hold", lsb_rdata, 32'h0000AB34);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
